// File: rtl/cdb_broadcaster.sv
// Common data bus broadcaster: queues functional-unit results and broadcasts up to WAYS per cycle, oldest first.
// Optional same-cycle bypass when the queue is empty is enabled by defining CDB_BYPASS_EN.
`ifndef WAYS
`define WAYS 2
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef PRF
`define PRF 64
`endif

module cdb_broadcaster #(
  parameter int unsigned WAYS      = `WAYS,
  parameter int unsigned NUM_FU    = `WAYS,
  parameter int unsigned XLEN      = `XLEN,
  parameter int unsigned PRF       = `PRF,
  parameter int unsigned BUF_DEPTH = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_FU-1:0]               fu_done,
  input  logic [NUM_FU*$clog2(PRF)-1:0]   fu_prf_idx,
  input  logic [NUM_FU*XLEN-1:0]          fu_data,
  output logic [NUM_FU-1:0]               ALU_occupied,
  output logic [WAYS-1:0]                 CDB_valid,
  output logic [WAYS*$clog2(PRF)-1:0]     CDB_PRF_idx,
  output logic [WAYS*XLEN-1:0]            CDB_Data,
  output logic [$clog2(BUF_DEPTH):0]      buf_count
);

  localparam int unsigned TAGW = $clog2(PRF);
  localparam int unsigned PTRW = $clog2(BUF_DEPTH);
  localparam int unsigned CNTW = PTRW + 1;

  logic [TAGW-1:0] r_tag  [BUF_DEPTH];
  logic [XLEN-1:0] r_data [BUF_DEPTH];
  logic [PTRW-1:0] r_head;
  logic [PTRW-1:0] r_tail;
  logic [CNTW-1:0] r_count;

  logic [NUM_FU-1:0] w_done;
  logic [NUM_FU-1:0] w_acc;
  logic [NUM_FU-1:0] w_wr_en;
  logic [PTRW-1:0]   w_wr_ptr [NUM_FU];
  logic [CNTW-1:0]   w_n_out;
  logic [CNTW-1:0]   w_free;
  logic [CNTW-1:0]   w_n_acc;
  logic [CNTW-1:0]   w_n_enq;
`ifdef CDB_BYPASS_EN
  logic [NUM_FU-1:0] w_byp;
  logic [CNTW-1:0]   w_byp_slot [NUM_FU];
`endif

  // Requests are ignored while in reset so nothing leaks onto the bus or back-pressure.
  assign w_done  = fu_done & {NUM_FU{reset}};
  assign w_n_out = (r_count < CNTW'(WAYS)) ? r_count : CNTW'(WAYS);
  assign w_free  = CNTW'(BUF_DEPTH) - r_count + w_n_out;

  // Accept scan: lowest unit index first until free entries run out.
  always_comb begin
    w_acc   = '0;
    w_wr_en = '0;
    w_n_acc = '0;
    w_n_enq = '0;
`ifdef CDB_BYPASS_EN
    w_byp   = '0;
`endif
    for (int i = 0; i < int'(NUM_FU); i++) begin
      w_wr_ptr[i] = '0;
`ifdef CDB_BYPASS_EN
      w_byp_slot[i] = '0;
`endif
      if (w_done[i] && (w_n_acc < w_free)) begin
        w_acc[i] = 1'b1;
`ifdef CDB_BYPASS_EN
        if ((r_count == '0) && (w_n_acc < CNTW'(WAYS))) begin
          w_byp[i]      = 1'b1;
          w_byp_slot[i] = w_n_acc;
        end else begin
          w_wr_en[i]  = 1'b1;
          w_wr_ptr[i] = r_tail + PTRW'(w_n_enq);
          w_n_enq     = w_n_enq + CNTW'(1);
        end
`else
        w_wr_en[i]  = 1'b1;
        w_wr_ptr[i] = r_tail + PTRW'(w_n_enq);
        w_n_enq     = w_n_enq + CNTW'(1);
`endif
        w_n_acc = w_n_acc + CNTW'(1);
      end
    end
  end

  assign ALU_occupied = w_done & ~w_acc;
  assign buf_count    = r_count;

  // CDB slots are LSB-packed reads of the queue head (or bypassed results when empty).
  always_comb begin
    logic [PTRW-1:0] v_idx;
    CDB_valid   = '0;
    CDB_PRF_idx = '0;
    CDB_Data    = '0;
    v_idx       = '0;
    for (int k = 0; k < int'(WAYS); k++) begin
      v_idx = r_head + PTRW'(k);
      if (CNTW'(k) < w_n_out) begin
        CDB_valid[k]                  = 1'b1;
        CDB_PRF_idx[k*TAGW +: TAGW]   = r_tag[v_idx];
        CDB_Data[k*XLEN +: XLEN]      = r_data[v_idx];
      end
`ifdef CDB_BYPASS_EN
      for (int i = 0; i < int'(NUM_FU); i++) begin
        if (w_byp[i] && (w_byp_slot[i] == CNTW'(k))) begin
          CDB_valid[k]                = 1'b1;
          CDB_PRF_idx[k*TAGW +: TAGW] = fu_prf_idx[i*TAGW +: TAGW];
          CDB_Data[k*XLEN +: XLEN]    = fu_data[i*XLEN +: XLEN];
        end
      end
`endif
    end
  end

  // Queue pointers; power-of-two depth makes the pointer wrap implicit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTRW'(w_n_out);
      r_tail  <= r_tail + PTRW'(w_n_enq);
      r_count <= r_count + w_n_enq - w_n_out;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < int'(NUM_FU); i++) begin
      if (w_wr_en[i]) begin
        r_tag[w_wr_ptr[i]]  <= fu_prf_idx[i*TAGW +: TAGW];
        r_data[w_wr_ptr[i]] <= fu_data[i*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: doc/cdb_broadcaster.md
# cdb_broadcaster

Completion-side counterpart of the reservation station. It collects results from the functional units fed by the reservation station and drives the common data bus (CDB) that the reservation station, and every other CDB listener, snoops. Results are buffered in a circular queue and broadcast oldest-first, up to `WAYS` per cycle, packed from the least significant CDB slot upward. When the queue cannot absorb a result, the block asserts per-unit `ALU_occupied` back-pressure, which stops issue to that unit.

## Interface
- `WAYS`, default `` `WAYS ``: number of CDB slots per cycle.
- `NUM_FU`, default `` `WAYS ``: number of functional-unit result ports.
- `XLEN`, default `` `XLEN ``: data width.
- `PRF`, default `` `PRF ``: number of physical registers; the tag width is $clog2(PRF).
- `BUF_DEPTH`, default 8: queue entries; must be a power of 2 and ≥ `WAYS`.

Ports:
- `clock` input 1: the single clock.
- `reset` input 1: asynchronous, active-low reset.
- `fu_done` input `NUM_FU`: unit i presents a result this cycle.
- `fu_prf_idx` input `NUM_FU`×$clog2(PRF): destination physical register of each result.
- `fu_data` input `NUM_FU`×`XLEN`: result value.
- `ALU_occupied` output `NUM_FU`: unit i's result was not accepted; the unit holds its result and receives no new issue.
- `CDB_valid` output `WAYS`: slot valid; always LSB-packed (0, 1, 11, 111, …).
- `CDB_PRF_idx` output `WAYS`×$clog2(PRF): broadcast tag.
- `CDB_Data` output `WAYS`×`XLEN`: broadcast value.
- `buf_count` output $clog2(BUF_DEPTH)+1: occupied entries, for debug.

## Operation
- State is a circular buffer of {prf_idx, data} entries plus the registers `head`, `tail` and `count`.
- Broadcast each cycle:
  - n_out = min(count, `WAYS`).
  - Slot k < n_out is driven from entry (head+k) mod `BUF_DEPTH`; higher slots have valid=0, and tag/data=0.
  - CDB outputs are combinational reads of registered state only.
- Accept each cycle:
  - free = `BUF_DEPTH` − count + n_out.
  - Scan `fu_done` from index 0 upward and accept units until free is exhausted.
  - Accepted results are written at tail, tail+1, … in ascending unit-index order.
  - `ALU_occupied[i]` = `fu_done[i]` & ~accepted[i]. It depends only on `fu_done` and registered count, so there is no combinational loop.
- Update on the clock edge:
  - head += n_out, mod `BUF_DEPTH`.
  - tail += n_acc, mod `BUF_DEPTH`.
  - count += n_acc − n_out.
- Ordering:
  - Results from earlier cycles broadcast first.
  - Within a cycle, the lower unit index broadcasts first.
  - A stalled unit's result is re-presented and competes again in the next cycle's scan.
- Boundaries:
  - Full buffer with `WAYS` entries draining: up to `WAYS` new results are accepted that cycle.
  - Empty buffer: all `CDB_valid` = 0.
  - Head/tail wrap-around: no gap and no reordering.

## Timing
- While `reset` is low: count = head = tail = 0; `CDB_valid` = 0; `CDB_PRF_idx` = 0; `CDB_Data` = 0; `ALU_occupied` = 0; `buf_count` = 0.
- Reset takes effect immediately (asynchronously). All queued results are discarded.
- Accepted result to CDB: 1 cycle when the queue ahead of it is empty. Otherwise 1 + ⌈(entries ahead)/`WAYS`⌉ − 1 extra cycles.
- `ALU_occupied` is valid in the same cycle as `fu_done`. The unit must hold `fu_prf_idx` and `fu_data` stable until it is accepted.
- Throughput: `WAYS` results per cycle sustained.

## Configuration
- Macro `CDB_BYPASS_EN`.
- Defined: when count == 0, accepted results beyond nothing ahead (up to `WAYS`, lowest unit indices first) drive the CDB in the same cycle and are not enqueued; latency 0. Any remaining accepted results are enqueued.
- Undefined: every result goes through the buffer; latency ≥ 1.
- The reset behaviour and `ALU_occupied` rule are identical in both builds.

## Test plan
Configuration for all scenarios: `WAYS`=2, `NUM_FU`=3, `BUF_DEPTH`=4, no bypass.

1. Reset: hold `reset`=0 with `fu_done`=111 → `CDB_valid`=00, `ALU_occupied`=000, `buf_count`=0.
2. Single result: `fu_done`=010, tag 7, data 0xAA at cycle t → at t+1, `CDB_valid`=01, slot0 tag 7, data 0xAA; at t+2, `CDB_valid`=00.
3. Back-pressure: `fu_done`=111 held for 3 cycles with distinct tags.
   - Cycle 0: count 0→3, `ALU_occupied`=000.
   - Cycle 1: 2 out, count 3→4.
   - Cycle 2: 2 out, free=2, so `ALU_occupied`=100.
4. Ordering: in scenario 3, CDB tag sequence equals acceptance order, lower unit index first, across the wrap at entry 3→0.
5. Async reset mid-operation: with count=3, drop `reset` between edges → `CDB_valid`=00 immediately. After release, a new single result appears alone at +1 cycle.
6. With `CDB_BYPASS_EN` defined: empty buffer, `fu_done`=011 tags 4 and 5 → same cycle `CDB_valid`=11, slot0 tag 4, slot1 tag 5; `buf_count` stays 0.
